// File: rtl/sod_frame_sequencer.sv
// sod_frame_sequencer
// Round-robin frame scheduler in front of a single stuff_or_data decision
// engine. One channel at a time is granted a frame: the engine is loaded with
// pm/cm and a start-of-frame, then fed exactly pm valid slots paced by
// slot_en. Decisions coming back from the engine are tagged with the owning
// channel, and the frame's data count is compared against cm at frame end.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req[N_CH]           level request per channel
//   cm_req              per-channel data count, channel i at [i*MPT_W +: MPT_W]
//   pm_cfg              frame length in slots (shared by all channels)
//   slot_en             slot opportunity strobe
//   grant[N_CH]         one-hot, one-cycle acknowledge (accept or reject)
//   cfg_err             pulses with grant when the request is rejected
//   busy                high from grant until frame end
//   sod_pm, sod_cm      engine pm/cm, held for the frame
//   sod_sof, sod_valid  engine start-of-frame / valid_in
//   sod_sof_out, sod_valid_out, sod_ds   engine sof_out / valid_out / ds
//   ds_out, ds_valid, ds_ch, ds_last     tagged decision stream
//   frame_done, frame_ok                 frame end pulse and cm check result
//   sync_err            pulse when the engine fails to echo sof
module sod_frame_sequencer #(
   parameter int MPT_W = 8,
   parameter int N_CH  = 4,
   parameter int CH_W  = $clog2(N_CH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_CH-1:0]         req,
   input  logic [N_CH*MPT_W-1:0]   cm_req,
   input  logic [MPT_W-1:0]        pm_cfg,
   input  logic                    slot_en,
   output logic [N_CH-1:0]         grant,
   output logic                    cfg_err,
   output logic                    busy,
   output logic [MPT_W-1:0]        sod_pm,
   output logic [MPT_W-1:0]        sod_cm,
   output logic                    sod_sof,
   output logic                    sod_valid,
   input  logic                    sod_sof_out,
   input  logic                    sod_valid_out,
   input  logic                    sod_ds,
   output logic                    ds_out,
   output logic                    ds_valid,
   output logic [CH_W-1:0]         ds_ch,
   output logic                    ds_last,
   output logic                    frame_done,
   output logic                    frame_ok,
   output logic                    sync_err
);

   localparam int CNT_W = MPT_W + 1;

   typedef enum logic [1:0] {IDLE, SOF, RUN, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [CH_W-1:0]    last_ch_q, last_ch_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [N_CH-1:0]    grant_q, grant_d;
   logic               cfg_err_q, cfg_err_d;
   logic               busy_q, busy_d;
   logic [MPT_W-1:0]   sod_pm_q, sod_pm_d;
   logic [MPT_W-1:0]   sod_cm_q, sod_cm_d;
   logic               sod_sof_q, sod_sof_d;
   logic [CNT_W-1:0]   issued_q, issued_d;
   logic [CNT_W-1:0]   ret_q, ret_d;
   logic [CNT_W-1:0]   dcnt_q, dcnt_d;
   logic               frame_done_q, frame_done_d;
   logic               frame_ok_q, frame_ok_d;
   logic               chk_q, chk_d;          // first RUN cycle: sof echo expected
   logic [1:0]         holdoff_q, holdoff_d;  // post-reset arbitration hold-off

   // Per-channel cm fields
   logic [MPT_W-1:0]   cm_arr [N_CH];
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_cm
      assign cm_arr[gi] = cm_req[gi*MPT_W +: MPT_W];
   end

   // Round-robin pick: scan from the highest offset down so the channel
   // closest after last_ch overwrites the others.
   logic [CH_W-1:0]    pick;
   logic [CH_W-1:0]    idx;
   logic               any_req;
   always_comb begin
      pick    = '0;
      idx     = '0;
      any_req = 1'b0;
      for (int i = N_CH; i >= 1; i--) begin
         idx = CH_W'((int'(last_ch_q) + i) % N_CH);
         if (req[idx]) begin
            pick    = idx;
            any_req = 1'b1;
         end
      end
   end

   logic [MPT_W-1:0]   cm_pick;
   logic [CNT_W-1:0]   pm_ext;
   logic               in_frame;
   assign cm_pick  = cm_arr[pick];
   assign pm_ext   = {1'b0, sod_pm_q};
   assign in_frame = (state_q == RUN) || (state_q == DRAIN);

   // Combinational slot metering and return path
   assign sod_valid = (state_q == RUN) && slot_en && (issued_q < pm_ext);
   assign sync_err  = (state_q == RUN) && chk_q && !sod_sof_out;
   assign ds_valid  = in_frame && sod_valid_out && !sync_err;
   assign ds_out    = sod_ds;
   assign ds_ch     = ch_q;
   assign ds_last   = ds_valid && (ret_q == pm_ext - CNT_W'(1));

   always_comb begin
      state_d      = state_q;
      last_ch_d    = last_ch_q;
      ch_d         = ch_q;
      grant_d      = '0;
      cfg_err_d    = 1'b0;
      busy_d       = busy_q;
      sod_pm_d     = sod_pm_q;
      sod_cm_d     = sod_cm_q;
      sod_sof_d    = 1'b0;
      issued_d     = issued_q;
      ret_d        = ret_q;
      dcnt_d       = dcnt_q;
      frame_done_d = 1'b0;
      frame_ok_d   = 1'b0;
      chk_d        = (state_q == SOF);
      holdoff_d    = (holdoff_q != 2'd0) ? holdoff_q - 2'd1 : 2'd0;

      case (state_q)
         IDLE: begin
            if (holdoff_q == 2'd0 && any_req) begin
               grant_d   = {{(N_CH-1){1'b0}}, 1'b1} << pick;
               last_ch_d = pick;
               if (pm_cfg == '0 || cm_pick > pm_cfg) begin
                  cfg_err_d = 1'b1;
               end else begin
                  sod_sof_d = 1'b1;
                  sod_pm_d  = pm_cfg;
                  sod_cm_d  = cm_pick;
                  ch_d      = pick;
                  busy_d    = 1'b1;
                  issued_d  = '0;
                  ret_d     = '0;
                  dcnt_d    = '0;
                  state_d   = SOF;
               end
            end
         end
         SOF: state_d = RUN;
         RUN: begin
            if (sync_err) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else if (sod_valid) begin
               issued_d = issued_q + CNT_W'(1);
               if (issued_q + CNT_W'(1) == pm_ext) state_d = DRAIN;
            end
         end
         default: ;   // DRAIN: wait for the last decision
      endcase

      // Return accounting; the last decision closes the frame from either state
      if (ds_valid) begin
         ret_d  = ret_q + CNT_W'(1);
         dcnt_d = dcnt_q + CNT_W'(sod_ds);
         if (ds_last) begin
            frame_done_d = 1'b1;
            frame_ok_d   = (dcnt_q + CNT_W'(sod_ds)) == {1'b0, sod_cm_q};
            busy_d       = 1'b0;
            state_d      = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_ch_q    <= CH_W'(N_CH - 1);
         ch_q         <= '0;
         grant_q      <= '0;
         cfg_err_q    <= 1'b0;
         busy_q       <= 1'b0;
         sod_pm_q     <= '0;
         sod_cm_q     <= '0;
         sod_sof_q    <= 1'b0;
         issued_q     <= '0;
         ret_q        <= '0;
         dcnt_q       <= '0;
         frame_done_q <= 1'b0;
         frame_ok_q   <= 1'b0;
         chk_q        <= 1'b0;
         holdoff_q    <= 2'd2;
      end else begin
         state_q      <= state_d;
         last_ch_q    <= last_ch_d;
         ch_q         <= ch_d;
         grant_q      <= grant_d;
         cfg_err_q    <= cfg_err_d;
         busy_q       <= busy_d;
         sod_pm_q     <= sod_pm_d;
         sod_cm_q     <= sod_cm_d;
         sod_sof_q    <= sod_sof_d;
         issued_q     <= issued_d;
         ret_q        <= ret_d;
         dcnt_q       <= dcnt_d;
         frame_done_q <= frame_done_d;
         frame_ok_q   <= frame_ok_d;
         chk_q        <= chk_d;
         holdoff_q    <= holdoff_d;
      end
   end

   assign grant      = grant_q;
   assign cfg_err    = cfg_err_q;
   assign busy       = busy_q;
   assign sod_pm     = sod_pm_q;
   assign sod_cm     = sod_cm_q;
   assign sod_sof    = sod_sof_q;
   assign frame_done = frame_done_q;
   assign frame_ok   = frame_ok_q;

endmodule

// File: doc/sod_frame_sequencer.md
# sod_frame_sequencer

Multi-channel frame scheduler in front of one stuff_or_data decision engine. It round-robin arbitrates among N_CH tributary channels requesting a frame. For each granted frame it loads the engine with pm/cm and a start-of-frame, then meters exactly pm valid slots into it, paced by a slot strobe. Returned data/stuff decisions are tagged with the owning channel, and the frame's data count is checked against cm.

## Interface
- MPT_W, 8: width of pm/cm and slot counters
- N_CH, 4: number of requesting channels
- CH_W, $clog2(N_CH): channel index width
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N_CH  level request per channel; requester drops it the cycle after its grant
- cm_req  in  N_CH*MPT_W  per-channel data count, channel i at [i*MPT_W +: MPT_W]
- pm_cfg  in  MPT_W  frame length in slots, common to all channels
- slot_en  in  1  slot opportunity strobe
- grant  out  N_CH  one-hot, one-cycle acknowledge of the accepted or rejected request
- cfg_err  out  1  one-cycle pulse with grant when the request is rejected
- busy  out  1  high from grant until frame_done
- sod_pm, sod_cm  out  MPT_W  engine pm/cm, held for the whole frame
- sod_sof  out  1  engine start-of-frame
- sod_valid  out  1  engine valid_in
- sod_sof_out, sod_valid_out, sod_ds  in  1  engine sof_out, valid_out, ds
- ds_out  out  1  decision, 1 = data, 0 = stuff
- ds_valid  out  1  ds_out qualifier
- ds_ch  out  CH_W  channel owning ds_out
- ds_last  out  1  marks the pm-th decision
- frame_done  out  1  one-cycle pulse at frame end
- frame_ok  out  1  valid with frame_done; 1 when the data count equals cm
- sync_err  out  1  one-cycle pulse when the engine fails to echo sof

## Operation
- States: IDLE, SOF, RUN, DRAIN.
- IDLE, when any req is high:
  - Pick the first requesting channel after last_ch, wrapping.
  - Latch pm_cfg into pm_l and that channel's cm into cm_l.
  - Set last_ch to the picked channel.
  - Register grant one-hot.
- Reject condition: pm_cfg == 0 or cm > pm_cfg.
  - On reject: grant plus cfg_err pulse, stay IDLE, no engine activity.
- On accept: sod_sof <= 1, sod_pm <= pm_l, sod_cm <= cm_l, busy <= 1, go to SOF.
- SOF lasts one cycle. sod_sof is high only here and sod_valid is 0. Next state is RUN.
- The cycle after SOF, sod_sof_out must be 1.
  - If it is not: sync_err pulse, abort to IDLE, busy <= 0, no frame_done.
- RUN:
  - sod_valid = slot_en, combinational, only while issued < pm_l.
  - issued increments on each sod_valid.
  - When issued reaches pm_l, go to DRAIN. No sod_valid is produced in DRAIN.
- Return path (combinational):
  - ds_valid = sod_valid_out while state is RUN or DRAIN.
  - ds_out = sod_ds; ds_ch = the active channel register.
  - A returned counter ret counts ds_valid; ds_last is high when ret == pm_l-1 and ds_valid.
  - A data counter dcnt counts ds_valid & ds_out.
- The cycle after ds_last, all registered:
  - frame_done = 1.
  - frame_ok = (dcnt including the last decision) == cm_l.
  - busy <= 0, state IDLE.
- Outside RUN/DRAIN, sod_valid_out is ignored and ds_valid stays 0.
- Counters are MPT_W+1 bits wide. There is no wrap within a frame because pm ≤ 2^MPT_W-1.

## Timing
- Reset values: grant=0, cfg_err=0, busy=0, sod_pm=0, sod_cm=0, sod_sof=0, sod_valid=0, ds_valid=0, ds_last=0, frame_done=0, frame_ok=0, sync_err=0.
- Reset also sets state=IDLE and last_ch=N_CH-1, so channel 0 wins first.
- Arbitration: req high at edge k → grant and sod_sof in cycle k+1 → RUN from cycle k+2.
- Engine latency is 1 cycle: sod_valid in cycle t → ds_valid in cycle t+1.
- Last slot in cycle t → ds_last in t+1 → frame_done in t+2 → earliest next grant in t+3.
- slot_en gaps stall the frame indefinitely; no timeout.
- req changes after grant have no effect on the current frame. cm_req and pm_cfg are sampled only at arbitration.
- rst mid-frame:
  - Sequencer returns to IDLE next cycle; late engine returns are suppressed.
  - Engine resynchronisation is the top level's duty. The sequencer issues no sod_sof for 2 cycles after rst deasserts.

## Test plan
- Single frame: ch1 req, pm=8, cm=5, slot_en always 1 → grant=0010; sod_sof for 1 cycle; 8 sod_valid; 8 ds_valid with ds_ch=1 and five 1s; ds_last on the 8th; frame_done with frame_ok=1.
- Round-robin: ch0, ch2 and ch3 requesting continuously, pm=4 → grants in order 0, 2, 3, 0; each frame issues exactly 4 slots.
- Rejects: pm_cfg=0, and separately cm=9 with pm=8 → grant plus cfg_err, no sod_sof; the next channel is served on the following cycle.
- Slot pacing: slot_en asserted 1 cycle in 3, pm=6 → 6 sod_valid only on slot_en cycles; ds_valid one cycle after each.
- Engine fault: hold sod_sof_out=0 → sync_err in the cycle after SOF, busy drops, no frame_done.
- Edge cases:
  - pm=1, cm=1 → single slot with ds_last on the first return.
  - rst during RUN after 3 of 8 slots → all outputs 0 next cycle, no sod_sof for 2 cycles.
